// File: rtl/mem_responder_pkg.sv
// Shared widths, default MMIO decode address and FSM state encoding for mem_responder.
package mem_responder_pkg;
  localparam int ADDR_W = 8;
  localparam int DATA_W = 16;
  localparam logic [ADDR_W-1:0] DEFAULT_MMIO_ADDR = 8'hFF;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } mr_state_t;
endpackage

// File: rtl/mem_responder_ram.sv
// Synchronous single-port 256x16 RAM, one-cycle registered read; rdata holds between enabled reads.
// No backpressure: the access completes on every clock edge where en is high.
module mem_responder_ram
  import mem_responder_pkg::*;
(
  input  logic              clk,
  input  logic              en,
  input  logic              we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] wdata,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [0:(1<<ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (en) begin
      if (we) begin
        mem[addr] <= wdata;
      end else begin
        rdata <= mem[addr];
      end
    end
  end

endmodule

// File: rtl/mem_responder.sv
// Load/store responder with programmable latency (rsp_valid WAIT_CYCLES+1 cycles after acceptance) and one MMIO register.
// Holds response until rsp_ready; req_ready only in IDLE. MEM_RESPONDER_STATS_EN enables saturating rd/wr counters.
module mem_responder
  import mem_responder_pkg::*;
#(
  parameter int                WAIT_CYCLES = 2,
  parameter logic [ADDR_W-1:0] MMIO_ADDR   = DEFAULT_MMIO_ADDR
)
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [DATA_W-1:0] io_out,
  output logic [15:0]       rd_count,
  output logic [15:0]       wr_count
);

  localparam int CW = ($clog2(WAIT_CYCLES + 1) < 1) ? 1 : $clog2(WAIT_CYCLES + 1);
  localparam logic [CW-1:0] WAIT_LD = CW'(WAIT_CYCLES);
  localparam logic [CW-1:0] CNT_ONE = CW'(1);
  localparam bit            NO_WAIT = (WAIT_CYCLES == 0);

  mr_state_t         state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              we_q;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] io_out_q;
  logic [DATA_W-1:0] rsp_reg_q;
  logic              from_ram_q;
  logic              commit;
  logic              accept;
  logic              c_we;
  logic [ADDR_W-1:0] c_addr;
  logic [DATA_W-1:0] c_wdata;
  logic              is_mmio;
  logic [DATA_W-1:0] ram_rdata;

  assign accept = (state_q == IDLE) && req_valid;

  // With zero wait the commit happens on the acceptance edge, so the live request is used.
  assign c_we    = (state_q == IDLE) ? req_we    : we_q;
  assign c_addr  = (state_q == IDLE) ? req_addr  : addr_q;
  assign c_wdata = (state_q == IDLE) ? req_wdata : wdata_q;
  assign is_mmio = (c_addr == MMIO_ADDR);

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    commit    = 1'b0;
    req_ready = 1'b0;
    rsp_valid = 1'b0;
    case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) begin
          if (NO_WAIT) begin
            commit  = 1'b1;
            state_d = RESP;
          end else begin
            cnt_d   = WAIT_LD;
            state_d = BUSY;
          end
        end
      end
      BUSY: begin
        cnt_d = cnt_q - CNT_ONE;
        if (cnt_q == CNT_ONE) begin
          commit  = 1'b1;
          state_d = RESP;
        end
      end
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      io_out_q   <= '0;
      rsp_reg_q  <= '0;
      from_ram_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        we_q    <= req_we;
        addr_q  <= req_addr;
        wdata_q <= req_wdata;
      end
      if (commit) begin
        if (c_we) begin
          rsp_reg_q  <= c_wdata;
          from_ram_q <= 1'b0;
          if (is_mmio) io_out_q <= c_wdata;
        end else begin
          rsp_reg_q  <= io_out_q;
          from_ram_q <= !is_mmio;
        end
      end
    end
  end

  // RAM read data lands in the RAM's own output register; only enabled on commit so it stays stable in RESP.
  mem_responder_ram u_ram (
    .clk   (clk),
    .en    (commit && !is_mmio),
    .we    (c_we),
    .addr  (c_addr),
    .wdata (c_wdata),
    .rdata (ram_rdata)
  );

  assign rsp_rdata = from_ram_q ? ram_rdata : rsp_reg_q;
  assign io_out    = io_out_q;

`ifdef MEM_RESPONDER_STATS_EN
  logic [15:0] rd_q, wr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_q <= '0;
      wr_q <= '0;
    end else if (commit) begin
      if (c_we && (wr_q != 16'hFFFF)) wr_q <= wr_q + 16'd1;
      if (!c_we && (rd_q != 16'hFFFF)) rd_q <= rd_q + 16'd1;
    end
  end

  assign rd_count = rd_q;
  assign wr_count = wr_q;
`else
  assign rd_count = 16'h0000;
  assign wr_count = 16'h0000;
`endif

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench: WAIT_CYCLES=2 and WAIT_CYCLES=0 instances, scoreboard queue of expected response data.
module tb_mem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, rst0_n;
  logic        req_valid, req_valid0, req_we, rsp_ready;
  logic [7:0]  req_addr;
  logic [15:0] req_wdata;
  logic        req_ready, rsp_valid, req_ready0, rsp_valid0;
  logic [15:0] rsp_rdata, io_out, rd_count, wr_count;
  logic [15:0] rsp_rdata0, io_out0, rd_count0, wr_count0;

  int total = 0;
  int bad   = 0;
  logic [15:0] exp_q [$];

  mem_responder #(.WAIT_CYCLES(2), .MMIO_ADDR(8'hFF)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
    .io_out(io_out), .rd_count(rd_count), .wr_count(wr_count)
  );

  mem_responder #(.WAIT_CYCLES(0), .MMIO_ADDR(8'hFF)) dut0 (
    .clk(clk), .rst_n(rst0_n),
    .req_valid(req_valid0), .req_ready(req_ready0), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid0), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata0),
    .io_out(io_out0), .rd_count(rd_count0), .wr_count(wr_count0)
  );

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Present a request, let it be accepted, then wait (bounded) for the response and score it.
  task automatic issue(input bit u, input logic we, input logic [7:0] a, input logic [15:0] d,
                       input logic [15:0] exp, input int lat);
    int n;
    req_we = we; req_addr = a; req_wdata = d;
    if (u) req_valid0 = 1'b1; else req_valid = 1'b1;
    chk("req_ready_idle", 16'(u ? req_ready0 : req_ready), 16'd1);
    @(posedge clk); #1;
    req_valid = 1'b0; req_valid0 = 1'b0;
    exp_q.push_back(exp);
    n = 1;
    while (!(u ? rsp_valid0 : rsp_valid) && n < 40) begin
      @(posedge clk); #1;
      n++;
    end
    chk("rsp_latency", 16'(n), 16'(lat));
    chk("rsp_valid", 16'(u ? rsp_valid0 : rsp_valid), 16'd1);
    chk("rsp_rdata", u ? rsp_rdata0 : rsp_rdata, exp_q.pop_front());
  endtask

  task automatic txn(input bit u, input logic we, input logic [7:0] a, input logic [15:0] d,
                     input logic [15:0] exp, input int lat);
    issue(u, we, a, d, exp, lat);
    @(posedge clk); #1;
    chk("back_to_idle", 16'(u ? rsp_valid0 : rsp_valid), 16'd0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; rst0_n = 1'b0;
    req_valid = 1'b0; req_valid0 = 1'b0;
    req_we = 1'b0; req_addr = 8'h00; req_wdata = 16'h0000;
    rsp_ready = 1'b1;
    #1;
    chk("rst_req_ready", 16'(req_ready), 16'd1);
    chk("rst_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("rst_rsp_rdata", rsp_rdata, 16'h0000);
    chk("rst_io_out", io_out, 16'h0000);
    chk("rst0_rsp_valid", 16'(rsp_valid0), 16'd0);
    chk("rst0_io_out", io_out0, 16'h0000);
    repeat (2) @(posedge clk);
    #1; rst_n = 1'b1; rst0_n = 1'b1;

    // asynchronous reset while a response is being held
    rsp_ready = 1'b0;
    issue(0, 1'b1, 8'hFF, 16'h5555, 16'h5555, 3);
    chk("t1_io_before", io_out, 16'h5555);
    chk("t1_ready_resp", 16'(req_ready), 16'd0);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("t1_req_ready", 16'(req_ready), 16'd1);
    chk("t1_rsp_valid", 16'(rsp_valid), 16'd0);
    chk("t1_rsp_rdata", rsp_rdata, 16'h0000);
    chk("t1_io_out", io_out, 16'h0000);
    chk("t1_rd_count", rd_count, 16'h0000);
    chk("t1_wr_count", wr_count, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1; rsp_ready = 1'b1;

    // store/load round trip
    txn(0, 1'b1, 8'h10, 16'd59, 16'd59, 3);
    txn(0, 1'b0, 8'h10, 16'h0000, 16'd59, 3);

    // MMIO path
    issue(0, 1'b1, 8'hFF, 16'hBEEF, 16'hBEEF, 3);
    chk("t3_io_out", io_out, 16'hBEEF);
    @(posedge clk); #1;
    txn(0, 1'b0, 8'hFF, 16'h0000, 16'hBEEF, 3);
    txn(0, 1'b0, 8'h10, 16'h0000, 16'd59, 3);

    // backpressure with a competing request
    rsp_ready = 1'b0;
    issue(0, 1'b0, 8'h10, 16'h0000, 16'd59, 3);
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'hAAAA; req_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      chk("t4_rsp_valid_hold", 16'(rsp_valid), 16'd1);
      chk("t4_rsp_rdata_hold", rsp_rdata, 16'd59);
      chk("t4_req_ready_low", 16'(req_ready), 16'd0);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    chk("t4_idle_ready", 16'(req_ready), 16'd1);
    chk("t4_idle_valid", 16'(rsp_valid), 16'd0);
    @(posedge clk); #1;
    chk("t4_no_phantom", 16'(rsp_valid), 16'd0);

    // reset during BUSY drops the uncommitted store
    txn(0, 1'b1, 8'h20, 16'h0001, 16'h0001, 3);
    req_we = 1'b1; req_addr = 8'h20; req_wdata = 16'h1234; req_valid = 1'b1;
    @(posedge clk); #1;
    req_valid = 1'b0;
    chk("t5_busy_ready", 16'(req_ready), 16'd0);
    chk("t5_busy_valid", 16'(rsp_valid), 16'd0);
    #3; rst_n = 1'b0;
    #1;
    chk("t5_rst_valid", 16'(rsp_valid), 16'd0);
    chk("t5_rst_io_out", io_out, 16'h0000);
    @(posedge clk); #1;
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t5_no_rsp", 16'(rsp_valid), 16'd0);
    txn(0, 1'b0, 8'h20, 16'h0000, 16'h0001, 3);
    chk("t5_io_out", io_out, 16'h0000);

    // zero-wait instance, back-to-back
    txn(1, 1'b1, 8'h01, 16'h1111, 16'h1111, 1);
    txn(1, 1'b1, 8'h02, 16'h2222, 16'h2222, 1);
    txn(1, 1'b1, 8'hFF, 16'h3333, 16'h3333, 1);
    txn(1, 1'b0, 8'h01, 16'h0000, 16'h1111, 1);
    txn(1, 1'b0, 8'hFF, 16'h0000, 16'h3333, 1);
    chk("t6_io_out", io_out0, 16'h3333);
`ifdef MEM_RESPONDER_STATS_EN
    chk("t6_wr_count", wr_count0, 16'd3);
    chk("t6_rd_count", rd_count0, 16'd2);
`else
    chk("t6_wr_count", wr_count0, 16'd0);
    chk("t6_rd_count", rd_count0, 16'd0);
`endif
    chk("t6_q_empty", 16'(exp_q.size()), 16'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
